// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared types for the EX-stage control-flow sequencer: jump condition codes
// and the redirect/flush state encoding.
package branch_redirect_ctrl_pkg;

  typedef enum logic [2:0] {
    COND_EQ = 3'd0,
    COND_NE = 3'd1,
    COND_GT = 3'd2,
    COND_LT = 3'd3,
    COND_GE = 3'd4,
    COND_LE = 3'd5
  } cond_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_t;

  localparam int unsigned FLUSH_CNT_W = 4;

endpackage

// File: rtl/branch_redirect_ctrl_jump_cond.sv
// Evaluates a conditional jump against the {N,Z,C,V} flags.
// Codes 6 and 7 are reserved and never taken.
module jump_cond_ctrl
  import branch_redirect_ctrl_pkg::*;
(
  input  logic       jump_cond,
  input  logic [2:0] cond_type,
  input  logic [3:0] flags,
  output logic       cond_taken
);

  logic flag_n;
  logic flag_z;
  logic flag_v;
  logic unused_carry;
  logic ge;
  logic gt;
  logic cond_true;

  assign flag_n       = flags[3];
  assign flag_z       = flags[2];
  assign unused_carry = flags[1];
  assign flag_v       = flags[0];

  assign ge = (flag_n == flag_v);
  assign gt = ~flag_z & ge;

  // Condition-code decode; reserved codes fall through to not-taken.
  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond_type))
      COND_EQ: cond_true = flag_z;
      COND_NE: cond_true = ~flag_z;
      COND_GT: cond_true = gt;
      COND_LT: cond_true = ~ge;
      COND_GE: cond_true = ge;
      COND_LE: cond_true = ~gt;
      default: cond_true = 1'b0;
    endcase
  end

  assign cond_taken = jump_cond & cond_true;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage control-flow sequencer: owns NZCV, resolves jumps, runs the
// redirect handshake to fetch and the following wrong-path flush window.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic              ex_jump,
  input  logic              ex_jump_cond,
  input  logic [2:0]        ex_cond_type,
  input  logic [ADDR_W-1:0] ex_target,
  input  logic              ex_set_flags,
  input  logic [3:0]        alu_flags,
  output logic [3:0]        flags_q,
  output logic              redirect_valid,
  input  logic              redirect_ready,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [CNT_W-1:0]  taken_cnt
);

  ctrl_state_t            state_q;
  ctrl_state_t            state_d;
  logic [3:0]             flags_d;
  logic [ADDR_W-1:0]      pc_q;
  logic [ADDR_W-1:0]      pc_d;
  logic [FLUSH_CNT_W-1:0] fcnt_q;
  logic [FLUSH_CNT_W-1:0] fcnt_d;
  logic [CNT_W-1:0]       taken_cnt_q;
  logic [CNT_W-1:0]       taken_cnt_d;
  logic                   redirect_valid_q;
  logic                   flush_q;
  logic                   fire;
  logic                   cond_taken;
  logic                   taken;

  jump_cond_ctrl u_jump_cond (
    .jump_cond  (ex_jump_cond),
    .cond_type  (ex_cond_type),
    .flags      (flags_q),
    .cond_taken (cond_taken)
  );

  assign fire  = ex_valid & ~stall & (state_q == RUN);
  assign taken = ex_jump | cond_taken;

  // Next-state, flag write, target capture and counters.
  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    pc_d        = pc_q;
    fcnt_d      = fcnt_q;
    taken_cnt_d = taken_cnt_q;

    // Only a RUN-state fire may touch flags; jumps read flags_q, i.e. the old value.
    if (fire && ex_set_flags) begin
      flags_d = alu_flags;
    end else begin
      flags_d = flags_q;
    end

    case (state_q)
      RUN: begin
        if (fire && taken) begin
          state_d = REDIRECT;
          pc_d    = ex_target;
          if (taken_cnt_q != {CNT_W{1'b1}}) begin
            taken_cnt_d = taken_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            taken_cnt_d = taken_cnt_q;
          end
        end else begin
          state_d = RUN;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = FLUSH;
          fcnt_d  = FLUSH_CNT_W'(FLUSH_CYCLES - 1);
        end else begin
          state_d = REDIRECT;
        end
      end
      FLUSH: begin
        if (fcnt_q == {FLUSH_CNT_W{1'b0}}) begin
          state_d = RUN;
        end else begin
          fcnt_d = fcnt_q - {{(FLUSH_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and output registers; outputs follow state_d so they are glitch-free flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= RUN;
      flags_q          <= 4'b0000;
      pc_q             <= {ADDR_W{1'b0}};
      fcnt_q           <= {FLUSH_CNT_W{1'b0}};
      taken_cnt_q      <= {CNT_W{1'b0}};
      redirect_valid_q <= 1'b0;
      flush_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      flags_q          <= flags_d;
      pc_q             <= pc_d;
      fcnt_q           <= fcnt_d;
      taken_cnt_q      <= taken_cnt_d;
      redirect_valid_q <= (state_d == REDIRECT);
      flush_q          <= (state_d != RUN);
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = pc_q;
  assign flush_if_id    = flush_q;
  assign flush_id_ex    = flush_q;
  assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench: directed vector table, counter saturation sequence,
// then randomized traffic checked against a behavioural model.
module tb_branch_redirect_ctrl;

  localparam int FC     = 2;
  localparam int CW     = 4;
  localparam int CNTMAX = 15;

  logic        clk = 1'b0;
  logic        rst, stall, ex_valid, ex_jump, ex_jump_cond, ex_set_flags, redirect_ready;
  logic [2:0]  ex_cond_type;
  logic [31:0] ex_target;
  logic [3:0]  alu_flags;
  logic [3:0]  flags_q;
  logic        redirect_valid, flush_if_id, flush_id_ex;
  logic [31:0] redirect_pc;
  logic [CW-1:0] taken_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: pending redirect flag plus flush cycles still owed.
  logic [3:0]  m_flags;
  bit          m_pend;
  int          m_frem;
  logic [31:0] m_pc;
  int          m_cnt;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.ADDR_W(32), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_jump(ex_jump),
    .ex_jump_cond(ex_jump_cond), .ex_cond_type(ex_cond_type), .ex_target(ex_target),
    .ex_set_flags(ex_set_flags), .alu_flags(alu_flags), .flags_q(flags_q),
    .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .taken_cnt(taken_cnt)
  );

  typedef struct {
    logic rst, stall, valid, jump, jcond;
    logic [2:0] ct;
    logic [31:0] tgt;
    logic setf;
    logic [3:0] alu;
    logic rdy;
    logic [3:0] ef;
    logic erv;
    logic [31:0] epc;
    logic efl;
    logic [3:0] ecnt;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic r, s, v, j, jc, input logic [2:0] ct,
                              input logic [31:0] tgt, input logic sf, input logic [3:0] alu,
                              input logic rdy, input logic [3:0] ef, input logic erv,
                              input logic [31:0] epc, input logic efl, input logic [3:0] ecnt);
    vec_t x;
    x.rst = r; x.stall = s; x.valid = v; x.jump = j; x.jcond = jc; x.ct = ct;
    x.tgt = tgt; x.setf = sf; x.alu = alu; x.rdy = rdy;
    x.ef = ef; x.erv = erv; x.epc = epc; x.efl = efl; x.ecnt = ecnt;
    return x;
  endfunction

  function automatic bit m_cond(input logic [2:0] ct, input logic [3:0] f);
    bit n, z, v;
    n = f[3]; z = f[2]; v = f[0];
    case (ct)
      3'd0: return z;
      3'd1: return !z;
      3'd2: return !z && (n == v);
      3'd3: return n != v;
      3'd4: return n == v;
      3'd5: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, s, v, j, jc, input logic [2:0] ct,
                       input logic [31:0] tgt, input logic sf, input logic [3:0] alu,
                       input logic rdy);
    rst = r; stall = s; ex_valid = v; ex_jump = j; ex_jump_cond = jc;
    ex_cond_type = ct; ex_target = tgt; ex_set_flags = sf; alu_flags = alu;
    redirect_ready = rdy;
  endtask

  // One clock: model consumes the inputs seen at the edge; outputs settle by #1.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_flags = 4'd0; m_pend = 0; m_frem = 0; m_pc = 32'd0; m_cnt = 0;
    end else if (m_pend) begin
      if (redirect_ready) begin
        m_pend = 0;
        m_frem = FC;
      end
    end else if (m_frem > 0) begin
      m_frem--;
    end else if (ex_valid && !stall) begin
      if (ex_jump || (ex_jump_cond && m_cond(ex_cond_type, m_flags))) begin
        m_pend = 1;
        m_pc   = ex_target;
        m_cnt  = (m_cnt < CNTMAX) ? m_cnt + 1 : CNTMAX;
      end
      if (ex_set_flags) m_flags = alu_flags;
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " flags"}, {28'd0, flags_q}, {28'd0, m_flags});
    chk({tag, " rvalid"}, {31'd0, redirect_valid}, {31'd0, m_pend});
    chk({tag, " rpc"}, redirect_pc, m_pc);
    chk({tag, " flush_if_id"}, {31'd0, flush_if_id}, {31'd0, (m_pend || m_frem > 0)});
    chk({tag, " flush_id_ex"}, {31'd0, flush_id_ex}, {31'd0, (m_pend || m_frem > 0)});
    chk({tag, " cnt"}, {28'd0, taken_cnt}, 32'(m_cnt));
  endtask

  initial begin
    //               rst s v j jc ct    tgt      sf alu     rdy  eflags  rv pc       fl cnt
    tbl[0]  = mk(1, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 0, 4'h0, 0, 32'h0,   0, 4'd0);
    tbl[1]  = mk(0, 0, 1, 0, 0, 3'd0, 32'h0,   1, 4'h4, 0, 4'h4, 0, 32'h0,   0, 4'd0);
    tbl[2]  = mk(0, 0, 1, 0, 1, 3'd0, 32'h100, 0, 4'h0, 0, 4'h4, 1, 32'h100, 1, 4'd1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 1, 4'h4, 0, 32'h100, 1, 4'd1);
    tbl[4]  = mk(0, 0, 1, 1, 0, 3'd0, 32'h200, 1, 4'hF, 0, 4'h4, 0, 32'h100, 1, 4'd1);
    tbl[5]  = mk(0, 0, 1, 1, 0, 3'd0, 32'h200, 1, 4'hF, 0, 4'h4, 0, 32'h100, 0, 4'd1);
    tbl[6]  = mk(0, 0, 1, 0, 0, 3'd0, 32'h0,   1, 4'h8, 0, 4'h8, 0, 32'h100, 0, 4'd1);
    tbl[7]  = mk(0, 0, 1, 0, 1, 3'd4, 32'h300, 0, 4'h0, 0, 4'h8, 0, 32'h100, 0, 4'd1);
    tbl[8]  = mk(0, 0, 1, 0, 1, 3'd3, 32'h300, 0, 4'h0, 0, 4'h8, 1, 32'h300, 1, 4'd2);
    tbl[9]  = mk(0, 0, 1, 1, 0, 3'd0, 32'h999, 0, 4'h0, 0, 4'h8, 1, 32'h300, 1, 4'd2);
    tbl[10] = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 0, 4'h8, 1, 32'h300, 1, 4'd2);
    tbl[11] = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 1, 4'h8, 0, 32'h300, 1, 4'd2);
    tbl[12] = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 0, 4'h8, 0, 32'h300, 1, 4'd2);
    tbl[13] = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 0, 4'h8, 0, 32'h300, 0, 4'd2);
    tbl[14] = mk(0, 1, 1, 1, 0, 3'd0, 32'h400, 1, 4'h1, 0, 4'h8, 0, 32'h300, 0, 4'd2);
    tbl[15] = mk(0, 0, 1, 1, 0, 3'd0, 32'h500, 0, 4'h0, 0, 4'h8, 1, 32'h500, 1, 4'd3);
    tbl[16] = mk(1, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 0, 4'h0, 0, 32'h0,   0, 4'd0);
    tbl[17] = mk(0, 0, 1, 0, 1, 3'd6, 32'h600, 0, 4'h0, 0, 4'h0, 0, 32'h0,   0, 4'd0);
    tbl[18] = mk(0, 0, 1, 0, 1, 3'd7, 32'h600, 0, 4'h0, 0, 4'h0, 0, 32'h0,   0, 4'd0);
    tbl[19] = mk(0, 0, 1, 0, 1, 3'd4, 32'h700, 0, 4'h0, 0, 4'h0, 1, 32'h700, 1, 4'd1);
    tbl[20] = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 1, 4'h0, 0, 32'h700, 1, 4'd1);
    tbl[21] = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 0, 4'h0, 0, 32'h700, 1, 4'd1);
    tbl[22] = mk(0, 0, 0, 0, 0, 3'd0, 32'h0,   0, 4'h0, 0, 4'h0, 0, 32'h700, 0, 4'd1);

    drive(1, 0, 0, 0, 0, 3'd0, 32'h0, 0, 4'h0, 0);
    m_flags = 4'd0; m_pend = 0; m_frem = 0; m_pc = 32'd0; m_cnt = 0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].stall, tbl[i].valid, tbl[i].jump, tbl[i].jcond, tbl[i].ct,
            tbl[i].tgt, tbl[i].setf, tbl[i].alu, tbl[i].rdy);
      step();
      chk($sformatf("vec%0d flags", i), {28'd0, flags_q}, {28'd0, tbl[i].ef});
      chk($sformatf("vec%0d rvalid", i), {31'd0, redirect_valid}, {31'd0, tbl[i].erv});
      chk($sformatf("vec%0d rpc", i), redirect_pc, tbl[i].epc);
      chk($sformatf("vec%0d flush", i), {30'd0, flush_if_id, flush_id_ex},
          {30'd0, tbl[i].efl, tbl[i].efl});
      chk($sformatf("vec%0d cnt", i), {28'd0, taken_cnt}, {28'd0, tbl[i].ecnt});
    end

    // Saturation: 17 taken jumps from reset must stop the counter at all-ones.
    drive(1, 0, 0, 0, 0, 3'd0, 32'h0, 0, 4'h0, 0);
    step();
    for (int k = 0; k < 17; k++) begin
      drive(0, 0, 1, 1, 0, 3'd0, 32'h1000 + 32'(k), 0, 4'h0, 0);
      step();
      drive(0, 0, 0, 0, 0, 3'd0, 32'h0, 0, 4'h0, 1);
      step();
      drive(0, 0, 0, 0, 0, 3'd0, 32'h0, 0, 4'h0, 0);
      for (int w = 0; w < FC; w++) step();
    end
    chk("sat cnt", {28'd0, taken_cnt}, 32'd15);
    chk("sat last pc", redirect_pc, 32'h1010);
    check_model("sat");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 75), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 35), 3'($urandom_range(0, 7)), $urandom(),
            ($urandom_range(0, 99) < 40), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 50));
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
